// File: rtl/jt34xxx_pkg.sv
// jt34xxx CRTC shared definitions.
// Register indices, CTRL bit positions and the byte-lane merge helper.
package jt34xxx_pkg;

  localparam int R_HSEND   = 0;
  localparam int R_HBEND   = 1;
  localparam int R_HBSTART = 2;
  localparam int R_HTOTAL  = 3;
  localparam int R_VSEND   = 4;
  localparam int R_VBEND   = 5;
  localparam int R_VBSTART = 6;
  localparam int R_VTOTAL  = 7;
  localparam int R_CTRL    = 8;
  localparam int R_INTSTAT = 9;
  localparam int R_INTEN   = 10;
  localparam int R_VCNT    = 11;
  localparam int R_VINT0   = 12;

  localparam int C_EN  = 0;
  localparam int C_HSN = 1;
  localparam int C_VSN = 2;
  localparam int C_BYP = 3;

  function automatic logic [15:0] bmerge(
    input logic [15:0] old,
    input logic [15:0] d,
    input logic [1:0]  be
  );
    return {be[1] ? d[15:8] : old[15:8],
            be[0] ? d[7:0]  : old[7:0]};
  endfunction

endpackage

// File: rtl/jt34xxx_crtc_if.sv
// jt34xxx CRTC host register bus.
// Single-cycle write strobe with byte enables, registered read data.
interface jt34xxx_crtc_if;
  logic        we;
  logic [4:0]  addr;
  logic [1:0]  be;
  logic [15:0] din;
  logic [15:0] dout;

  modport master (
    output we, addr, be, din,
    input  dout
  );

  modport slave (
    input  we, addr, be, din,
    output dout
  );
endinterface

// File: rtl/jt34xxx_crtc_regs.sv
// jt34xxx CRTC host register file.
// Shadow/active timing, CTRL, line interrupts and readback.
module jt34xxx_crtc_regs
  import jt34xxx_pkg::*;
#(
  parameter int CW       = 12,
  parameter int NINT     = 2,
  parameter int HS_END   = 'h010,
  parameter int HB_END   = 'h020,
  parameter int HB_START = 'h1F0,
  parameter int H_TOTAL  = 'h1FF,
  parameter int VS_END   = 'h004,
  parameter int VB_END   = 'h010,
  parameter int VB_START = 'h0F0,
  parameter int V_TOTAL  = 'h0FF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jt34xxx_crtc_if.slave        bus,
  input  logic                 pxl_cen,
  input  logic [CW-1:0]        h_cnt,
  input  logic [CW-1:0]        v_cnt,
  output logic [7:0][CW-1:0]   act,
  output logic [2:0]           mode,
  output logic                 int_n
);

  localparam logic [7:0][CW-1:0] RST = {
    CW'(V_TOTAL), CW'(VB_START), CW'(VB_END), CW'(VS_END),
    CW'(H_TOTAL), CW'(HB_START), CW'(HB_END), CW'(HS_END)
  };

  logic [7:0][CW-1:0]   shd;
  logic [NINT-1:0][CW-1:0] vint;
  logic [NINT-1:0]      intstat;
  logic [NINT-1:0]      inten;
  logic [NINT-1:0]      set;
  logic [NINT-1:0]      clr;
  logic [3:0]           ctrl;
  logic [15:0]          rd;
  logic                 wrap;

  assign wrap  = pxl_cen && h_cnt == act[R_HTOTAL]
                 && v_cnt == act[R_VTOTAL];
  assign mode  = ctrl[2:0];
  assign int_n = ~|(intstat & inten);

  always_comb begin
    set = '0;
    for (int k = 0; k < NINT; k++)
      set[k] = pxl_cen && h_cnt == '0 && v_cnt == vint[k];
    clr = '0;
    if (bus.we && bus.be[0] && bus.addr == 5'(R_INTSTAT))
      clr = bus.din[NINT-1:0];
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      bus.addr < 5'd8:
        rd = 16'(shd[bus.addr[2:0]]);
      bus.addr == 5'(R_CTRL):    rd = 16'(ctrl);
      bus.addr == 5'(R_INTSTAT): rd = 16'(intstat);
      bus.addr == 5'(R_INTEN):   rd = 16'(inten);
      bus.addr == 5'(R_VCNT):    rd = 16'(v_cnt);
      default:                   rd = '0;
    endcase
    for (int k = 0; k < NINT; k++)
      if (bus.addr == 5'(R_VINT0 + k)) rd = 16'(vint[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd      <= RST;
      act      <= RST;
      ctrl     <= 4'h1;
      inten    <= '0;
      intstat  <= '0;
      vint     <= '0;
      bus.dout <= '0;
    end else begin
      bus.dout <= rd;
      for (int i = 0; i < 8; i++)
        if (bus.we && bus.addr == 5'(i))
          shd[i] <= CW'(bmerge(16'(shd[i]), bus.din, bus.be));
      // pending writes become visible only at a frame boundary
      if (ctrl[C_BYP] || wrap) act <= shd;
      if (bus.we && bus.be[0] && bus.addr == 5'(R_CTRL))
        ctrl <= bus.din[3:0];
      if (bus.we && bus.be[0] && bus.addr == 5'(R_INTEN))
        inten <= bus.din[NINT-1:0];
      for (int k = 0; k < NINT; k++)
        if (bus.we && bus.addr == 5'(R_VINT0 + k))
          vint[k] <= CW'(bmerge(16'(vint[k]), bus.din, bus.be));
      intstat <= (intstat & ~clr) | set;
    end
  end

endmodule

// File: rtl/jt34xxx_crtc.sv
// jt34xxx CRTC top: beam counters and sync/blank decode.
// Host registers live in jt34xxx_crtc_regs.
module jt34xxx_crtc
  import jt34xxx_pkg::*;
#(
  parameter int CW       = 12,
  parameter int NINT     = 2,
  parameter int HS_END   = 'h010,
  parameter int HB_END   = 'h020,
  parameter int HB_START = 'h1F0,
  parameter int H_TOTAL  = 'h1FF,
  parameter int VS_END   = 'h004,
  parameter int VB_END   = 'h010,
  parameter int VB_START = 'h0F0,
  parameter int V_TOTAL  = 'h0FF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  jt34xxx_crtc_if.slave bus,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          hs,
  output logic          vs,
  output logic          lhbl,
  output logic          lvbl,
  output logic          blank_n,
  output logic          int_n
);

  logic [7:0][CW-1:0] act;
  logic [2:0]         mode;
  logic               h_end;
  logic               v_end;

  jt34xxx_crtc_regs #(
    .CW(CW), .NINT(NINT),
    .HS_END(HS_END), .HB_END(HB_END),
    .HB_START(HB_START), .H_TOTAL(H_TOTAL),
    .VS_END(VS_END), .VB_END(VB_END),
    .VB_START(VB_START), .V_TOTAL(V_TOTAL)
  ) u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pxl_cen (pxl_cen),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .act     (act),
    .mode    (mode),
    .int_n   (int_n)
  );

  assign h_end   = h_cnt == act[R_HTOTAL];
  assign v_end   = v_cnt == act[R_VTOTAL];
  assign blank_n = lhbl & lvbl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hs    <= 1'b0;
      vs    <= 1'b0;
      lhbl  <= 1'b0;
      lvbl  <= 1'b0;
    end else if (pxl_cen) begin
      if (!mode[C_EN]) begin
        h_cnt <= '0;
        v_cnt <= '0;
        hs    <= mode[C_HSN];
        vs    <= mode[C_VSN];
        lhbl  <= 1'b0;
        lvbl  <= 1'b0;
      end else begin
        h_cnt <= h_end ? '0 : h_cnt + CW'(1);
        if (h_end) v_cnt <= v_end ? '0 : v_cnt + CW'(1);
        hs   <= (h_cnt < act[R_HSEND]) ^ mode[C_HSN];
        vs   <= (v_cnt < act[R_VSEND]) ^ mode[C_VSN];
        lhbl <= h_cnt >= act[R_HBEND] && h_cnt < act[R_HBSTART];
        lvbl <= v_cnt >= act[R_VBEND] && v_cnt < act[R_VBSTART];
      end
    end
  end

endmodule

// File: tb/tb_jt34xxx_crtc.sv
// jt34xxx CRTC directed testbench.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_jt34xxx_crtc;
  import jt34xxx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pxl_cen;
  logic [11:0] h_cnt, v_cnt;
  logic        hs, vs, lhbl, lvbl, blank_n, int_n;

  int checks = 0;
  int errors = 0;

  jt34xxx_crtc_if bus();

  jt34xxx_crtc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pxl_cen (pxl_cen),
    .bus     (bus),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .hs      (hs),
    .vs      (vs),
    .lhbl    (lhbl),
    .lvbl    (lvbl),
    .blank_n (blank_n),
    .int_n   (int_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d,
                    input logic [1:0] b);
    bus.we = 1'b1;
    bus.addr = 5'(a);
    bus.din = d;
    bus.be = b;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rd(input int a, output logic [15:0] d);
    bus.addr = 5'(a);
    @(negedge clk);
    d = bus.dout;
  endtask

  task automatic wait_hv(input int h, input int v, input int lim);
    int n = 0;
    while (!(h_cnt == 12'(h) && (v < 0 || v_cnt == 12'(v)))
           && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL wait_h%0h_v%0h: timeout after %0d, required match",
               h, v, lim);
    end
  endtask

  task automatic line(output int per, output int hsn, output int lbn);
    int n;
    per = 0; hsn = 0; lbn = 0;
    n = 0;
    while (h_cnt == 0 && n < 5000) begin @(negedge clk); n++; end
    n = 0;
    while (h_cnt != 0 && n < 5000) begin @(negedge clk); n++; end
    do begin
      hsn += int'(hs);
      lbn += int'(lhbl);
      @(negedge clk);
      per++;
    end while (h_cnt != 0 && per < 5000);
  endtask

  task automatic frame(output int cyc);
    wait_hv(0, 0, 20000);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(h_cnt == 0 && v_cnt == 0) && cyc < 20000);
  endtask

  initial begin
    logic [15:0] d;
    int per, hsn, lbn, cyc;
    logic [11:0] hp;
    logic hsp;
    rst_n = 1'b0;
    pxl_cen = 1'b1;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.be = '0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    chk("rst_h", h_cnt, 0);
    chk("rst_v", v_cnt, 0);
    chk("rst_hs", hs, 0);
    chk("rst_lhbl", lhbl, 0);
    chk("rst_int_n", int_n, 1);
    chk("rst_dout", bus.dout, 0);
    rst_n = 1'b1;
    rd(R_CTRL, d);    chk("rst_ctrl", d, 16'h0001);
    rd(R_HTOTAL, d);  chk("rst_htotal", d, 16'h01FF);
    rd(R_INTEN, d);   chk("rst_inten", d, 0);

    line(per, hsn, lbn);
    chk("line_per", per, 'h200);
    chk("line_hs", hsn, 'h10);
    chk("line_lhbl", lbn, 'h1D0);
    line(per, hsn, lbn);
    chk("line_per2", per, 'h200);
    wait_hv('h1F0, -1, 1000);
    chk("lhbl_at_1f0", lhbl, 1);
    @(negedge clk);
    chk("lhbl_after_1f0", lhbl, 0);

    wr(R_CTRL, 16'h0009, 2'b11);
    wr(R_HTOTAL, 16'h001F, 2'b11);
    wr(R_CTRL, 16'h0001, 2'b11);
    frame(cyc);
    chk("frame_cyc", cyc, 'h2000);

    wr(R_CTRL, 16'h0009, 2'b11);
    wr(R_HTOTAL, 16'h003F, 2'b11);
    wr(R_VTOTAL, 16'h004F, 2'b11);
    wr(R_HBEND, 16'h0004, 2'b11);
    wr(R_HBSTART, 16'h0030, 2'b11);
    wr(R_VBSTART, 16'h0048, 2'b11);
    wr(R_CTRL, 16'h0001, 2'b11);
    wait_hv(4, 'h20, 8000);
    chk("blank_hb_lo", blank_n, 0);
    @(negedge clk);
    chk("blank_hb_hi", blank_n, 1);
    wait_hv('h30, 'h20, 200);
    chk("blank_hs_hi", blank_n, 1);
    @(negedge clk);
    chk("blank_hs_lo", blank_n, 0);

    wait_hv(0, 'h40, 8000);
    wr(R_HTOTAL, 16'h001F, 2'b11);
    rd(R_HTOTAL, d);
    chk("shadow_read", d, 16'h001F);
    line(per, hsn, lbn);
    chk("pend_per", per, 'h40);
    wait_hv(5, 'h47, 2000);
    chk("lvbl_47", lvbl, 1);
    wait_hv(5, 'h48, 200);
    chk("lvbl_48", lvbl, 0);
    wait_hv(0, 0, 6000);
    line(per, hsn, lbn);
    chk("wrap_per", per, 'h20);

    wr(R_VINT0, 16'h0030, 2'b11);
    wr(R_INTSTAT, 16'h0003, 2'b01);
    wr(R_INTEN, 16'h0001, 2'b01);
    chk("int_idle", int_n, 1);
    begin
      int n = 0;
      while (int_n && n < 4000) begin @(negedge clk); n++; end
    end
    chk("int_v", v_cnt, 'h30);
    chk("int_h", h_cnt, 1);
    wr(R_INTSTAT, 16'h0001, 2'b01);
    chk("int_clr", int_n, 1);
    rd(R_INTSTAT, d);
    chk("intstat_clr", d[0], 0);

    wait_hv(0, 'h30, 4000);
    wr(R_INTSTAT, 16'h0001, 2'b01);
    chk("set_wins_int", int_n, 0);
    rd(R_INTSTAT, d);
    chk("set_wins_stat", d[0], 1);
    wr(R_INTSTAT, 16'h0003, 2'b01);

    wr(R_CTRL, 16'h0007, 2'b11);
    wait_hv(8, -1, 200);
    chk("hs_inv_act", hs, 0);
    wait_hv('h18, -1, 200);
    chk("hs_inv_idle", hs, 1);
    wait_hv(5, 2, 4000);
    chk("vs_inv_act", vs, 0);
    wait_hv(5, 'h10, 4000);
    chk("vs_inv_idle", vs, 1);

    wr(R_CTRL, 16'h0000, 2'b11);
    @(negedge clk);
    chk("dis_h", h_cnt, 0);
    chk("dis_v", v_cnt, 0);
    chk("dis_blank", blank_n, 0);
    chk("dis_hs", hs, 0);
    wr(R_VSEND, 16'hABCD, 2'b01);
    rd(R_VSEND, d);
    chk("be_lo", d, 16'h00CD);
    wr(R_VSEND, 16'h1234, 2'b10);
    rd(R_VSEND, d);
    chk("be_hi_trunc", d, 16'h02CD);
    wr(20, 16'hFFFF, 2'b11);
    rd(20, d);
    chk("unmapped", d, 0);

    wr(R_CTRL, 16'h0001, 2'b11);
    for (int i = 0; i < 12; i++) begin
      pxl_cen = (i % 4 == 0);
      hp = h_cnt;
      hsp = hs;
      @(negedge clk);
      if (pxl_cen)
        chk($sformatf("cen_step%0d", i), h_cnt,
            (hp == 12'h1F) ? 0 : hp + 1);
      else begin
        chk($sformatf("cen_hold%0d", i), h_cnt, hp);
        chk($sformatf("cen_hs%0d", i), hs, hsp);
      end
    end

    pxl_cen = 1'b1;
    bus.addr = 5'(R_HTOTAL);
    repeat (5) @(negedge clk);
    chk("dout_pre", bus.dout, 16'h001F);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_h", h_cnt, 0);
    chk("mid_rst_v", v_cnt, 0);
    chk("mid_rst_hs", hs, 0);
    chk("mid_rst_lvbl", lvbl, 0);
    chk("mid_rst_int", int_n, 1);
    chk("mid_rst_dout", bus.dout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_h", h_cnt, 1);
    rd(R_HTOTAL, d);
    chk("rst_shadow_ht", d, 16'h01FF);
    rd(R_VSEND, d);
    chk("rst_shadow_vs", d, 16'h0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt34xxx_crtc.md
JT34XXX_CRTC -- requirements
Module: jt34xxx_crtc

Interface
REQ-001 SHALL have parameter CW, default 12: width of horizontal/vertical counters and timing registers (8..16).
REQ-002 SHALL have parameter NINT, default 2: number of line-interrupt compare channels (1..4).
REQ-003 SHALL have parameters HS_END=0x010, HB_END=0x020, HB_START=0x1F0, H_TOTAL=0x1FF, VS_END=0x004, VB_END=0x010, VB_START=0x0F0, V_TOTAL=0x0FF: timing reset values.
REQ-004 SHALL have port clk  in  1: single system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, synchronous and active-low.
REQ-006 SHALL have port pxl_cen  in  1: pixel clock enable; counters advance only when high.
REQ-007 SHALL have ports we in 1, addr in 5, be in 2, din in 16: host write strobe, register index, byte enables [1]=high byte, write data.
REQ-008 SHALL have port dout  out  16: registered read data for addr.
REQ-009 SHALL have ports h_cnt out CW, v_cnt out CW: live beam position.
REQ-010 SHALL have ports hs, vs, lhbl, lvbl, blank_n out 1: sync (polarity per CTRL), active-high display flags, blank_n = lhbl & lvbl.
REQ-011 SHALL have port int_n  out  1: active-low interrupt, low while (INTSTAT & INTEN) != 0.

Function
REQ-012 Register map SHALL be: 0 HSEND, 1 HBEND, 2 HBSTART, 3 HTOTAL, 4 VSEND, 5 VBEND, 6 VBSTART, 7 VTOTAL, 8 CTRL, 9 INTSTAT, 10 INTEN, 11 VCNT (read-only), 12+k VINT[k] for k<NINT; other addresses read 0, writes ignored.
REQ-013 CTRL bits SHALL be: [0] enable, [1] hs active-low, [2] vs active-low, [3] shadow bypass; other bits read 0.
REQ-014 Writes SHALL update only bytes with be set; timing registers keep only bits [CW-1:0].
REQ-015 Writes to addresses 0..7 SHALL land in shadow registers; active copies load from shadow on the pxl_cen cycle where h_cnt==HTOTAL and v_cnt==VTOTAL (frame wrap), or immediately when CTRL[3]=1.
REQ-016 Reads of 0..7 SHALL return shadow values; read data SHALL appear on dout one clk after addr is presented.
REQ-017 On pxl_cen with CTRL[0]=1: h_cnt SHALL increment, wrapping HTOTAL->0; at that wrap v_cnt SHALL increment, wrapping VTOTAL->0.
REQ-018 With CTRL[0]=0: h_cnt and v_cnt SHALL hold 0, hs/vs inactive, lhbl=lvbl=0.
REQ-019 Registered outputs, updated on pxl_cen one cycle after the counter value: hs = (h_cnt < HSEND), vs = (v_cnt < VSEND), lhbl = (HBEND <= h_cnt < HBSTART), lvbl = (VBEND <= v_cnt < VBSTART), all from active registers, then polarity applied.
REQ-020 INTSTAT[k] SHALL set on the pxl_cen cycle where h_cnt==0 and v_cnt==VINT[k]; sticky.
REQ-021 Writing 1 to INTSTAT[k] SHALL clear it; a set event in the same cycle SHALL win.
REQ-022 HTOTAL or VTOTAL set below the current count SHALL take effect at the next frame wrap (shadowed); with bypass, the counter runs to 2^CW-1 and wraps to 0.
REQ-023 Counter arithmetic SHALL be CW bits, unsigned, modulo 2^CW.

Reset
REQ-024 With rst_n low at a clk edge: counters 0, CTRL=0x0001, INTSTAT=0, INTEN=0, VINT[k]=0, shadow and active timing = parameter values, dout=0, hs=vs=0, lhbl=lvbl=0, int_n=1.
REQ-025 Reset mid-frame SHALL discard pending shadow values and restart at h_cnt=v_cnt=0 on the first pxl_cen after release.

Structure
REQ-026 Package jt34xxx_pkg SHALL hold the register-index constants and CTRL bit positions.
REQ-027 Sub-module jt34xxx_crtc_regs SHALL hold the host register file, shadows, readback mux and INTSTAT/INTEN; the top holds counters and output decode.

Verification
REQ-028 Reset, pxl_cen=1 always, default params -> hs high for h_cnt 0..0x00F, line period 0x200 cycles, frame 0x100 lines, blank_n low at h_cnt 0x1F0.
REQ-029 Mid-frame write HTOTAL=0x0FF at v_cnt=0x40 -> line period stays 0x200 until frame wrap, then 0x100; readback returns 0x0FF immediately.
REQ-030 INTEN=0x1, VINT[0]=0x080 -> int_n falls when h_cnt=0, v_cnt=0x080; write INTSTAT=0x1 -> int_n rises next cycle.
REQ-031 Write INTSTAT=0x1 on the exact set cycle -> INTSTAT[0] stays 1, int_n stays low.
REQ-032 CTRL=0x0007 -> hs/vs inverted; CTRL=0x0000 -> counters at 0, blank_n low; be=2'b01 write of 0xABCD to VSEND -> only low byte changes.
REQ-033 pxl_cen high every 4th clk -> counter step and output update only on those cycles; rst_n pulse mid-line -> REQ-024 values.
